// File: rtl/datapath_pkg.sv
// Shared types for the single-bus register-transfer datapath: opcodes, sequencer
// states and the one-hot bus-source select.
package datapath_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SHL = 4'd4,
        OP_SHR = 4'd5,
        OP_SRA = 4'd6,
        OP_NOT = 4'd7,
        OP_NEG = 4'd8,
        OP_MUL = 4'd9,
        OP_MOV = 4'd10,
        OP_LDI = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T0   = 2'd1,
        ST_T1   = 2'd2,
        ST_T2   = 2'd3
    } state_e;

    typedef enum logic [3:0] {
        BUS_ZERO = 4'b0001,
        BUS_REG  = 4'b0010,
        BUS_IMM  = 4'b0100,
        BUS_ZLO  = 4'b1000
    } bus_sel_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_LDI;
    endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: Z = op(Y, B). Only MUL fills the upper half of Z.
module dp_alu
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]          i_op,
    input  logic [DATA_W-1:0]   i_y,
    input  logic [DATA_W-1:0]   i_b,
    output logic [2*DATA_W-1:0] o_z
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0]     w_sh;
    logic [2*DATA_W-1:0] w_y_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_lo;
    logic [DATA_W-1:0]   w_hi;

    assign w_sh = i_b[SH_W-1:0];
    // Sign-extending both operands makes the low 2W bits of an unsigned multiply the signed product.
    assign w_y_ext = {{DATA_W{i_y[DATA_W-1]}}, i_y};
    assign w_b_ext = {{DATA_W{i_b[DATA_W-1]}}, i_b};
    assign w_prod  = w_y_ext * w_b_ext;

    always_comb begin
        w_lo = '0;
        w_hi = '0;
        case (i_op)
            OP_ADD:         w_lo = i_y + i_b;
            OP_SUB:         w_lo = i_y - i_b;
            OP_AND:         w_lo = i_y & i_b;
            OP_OR:          w_lo = i_y | i_b;
            OP_SHL:         w_lo = i_y << w_sh;
            OP_SHR:         w_lo = i_y >> w_sh;
            OP_SRA:         w_lo = $signed(i_y) >>> w_sh;
            OP_NOT:         w_lo = ~i_y;
            OP_NEG:         w_lo = '0 - i_y;
            OP_MUL:         {w_hi, w_lo} = w_prod;
            OP_MOV, OP_LDI: w_lo = i_y;
            default:        w_lo = '0;
        endcase
    end

    assign o_z = {w_hi, w_lo};

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus datapath with register file, Y/Z/HI/LO and a four-state sequencer that
// retires one Ra <= Rb op Rc|imm transfer per accepted request.
module bus_datapath_seq
    import datapath_pkg::*;
#(
    parameter int   DATA_W   = 32,
    parameter int   NUM_REGS = 16,
    localparam int  REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    input  logic [REG_AW-1:0] rc,
    input  logic [DATA_W-1:0] imm,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] bus_data,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e              r_state;
    state_e              w_next;
    logic [3:0]          r_op;
    logic [REG_AW-1:0]   r_ra;
    logic [REG_AW-1:0]   r_rb;
    logic [REG_AW-1:0]   r_rc;
    logic [DATA_W-1:0]   r_imm;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   r_y;
    logic [2*DATA_W-1:0] r_z;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_result;
    logic                r_done;
    logic                r_err;

    bus_sel_e            w_bus_sel;
    logic [REG_AW-1:0]   w_rd_idx;
    logic [DATA_W-1:0]   w_rd_data;
    logic [DATA_W-1:0]   w_bus;
    logic [2*DATA_W-1:0] w_alu_z;
    logic                w_accept;
    logic                w_legal;
    logic                w_wr_reg;
    logic                w_wr_hilo;

    // Handshake: a request is taken on a clock edge where op_valid and op_ready are both high;
    // op_ready is high only in IDLE, so requests presented while busy are simply not taken.
    assign op_ready  = (r_state == ST_IDLE);
    assign w_accept  = op_valid && op_ready;
    assign w_legal   = op_is_legal(r_op);
    assign w_wr_reg  = (r_state == ST_T2) && w_legal && (r_op != OP_MUL);
    assign w_wr_hilo = (r_state == ST_T2) && (r_op == OP_MUL);
    assign w_rd_data = r_regs[w_rd_idx];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rc    <= '0;
            r_imm   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op  <= op_code;
                r_ra  <= ra;
                r_rb  <= rb;
                r_rc  <= rc;
                r_imm <= imm;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_bus_sel = BUS_ZERO;
        w_rd_idx  = r_rb;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_T0;
            ST_T0: begin
                w_next    = ST_T1;
                w_bus_sel = (r_op == OP_LDI) ? BUS_IMM : BUS_REG;
            end
            ST_T1: begin
                w_next    = ST_T2;
                w_rd_idx  = r_rc;
                w_bus_sel = BUS_REG;
            end
            ST_T2: begin
                w_next    = ST_IDLE;
                w_bus_sel = BUS_ZLO;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_bus = '0;
        case (w_bus_sel)
            BUS_REG: w_bus = w_rd_data;
            BUS_IMM: w_bus = r_imm;
            BUS_ZLO: w_bus = r_z[DATA_W-1:0];
            default: w_bus = '0;
        endcase
    end

    a_bus_onehot: assert property (@(posedge clk) disable iff (!clr) $onehot(w_bus_sel));

    dp_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op (r_op),
        .i_y  (r_y),
        .i_b  (w_bus),
        .o_z  (w_alu_z)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_y      <= '0;
            r_z      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= (r_state == ST_T2);
            r_err  <= (r_state == ST_T2) && !w_legal;
            if (r_state == ST_T0) r_y <= w_bus;
            if (r_state == ST_T1) r_z <= w_alu_z;
            if (r_state == ST_T2) r_result <= w_bus;
            if (w_wr_hilo) begin
                r_hi <= r_z[2*DATA_W-1:DATA_W];
                r_lo <= r_z[DATA_W-1:0];
            end
        end
    end

    // Operands are captured in Y and Z before the T2 write, so ra may alias rb or rc.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wr_reg) begin
            r_regs[r_ra] <= w_bus;
        end
    end

    assign done     = r_done;
    assign err      = r_err;
    assign result   = r_result;
    assign bus_data = w_bus;
    assign hi_out   = r_hi;
    assign lo_out   = r_lo;
    assign dbg_data = r_regs[dbg_addr];

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq: a negedge monitor models each accepted op,
// queues the expected result and checks it, err and latency when done pulses.
module tb_bus_datapath_seq;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_code;
    logic [AW-1:0] ra, rb, rc;
    logic [DW-1:0] imm;
    logic          done;
    logic          err;
    logic [DW-1:0] result;
    logic [DW-1:0] bus_data;
    logic [DW-1:0] hi_out;
    logic [DW-1:0] lo_out;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_acc = 0;
    int n_done = 0;

    logic [DW-1:0] exp_q[$];
    logic          err_q[$];
    int            acc_q[$];

    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] m_hi, m_lo;

    bus_datapath_seq #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk      (clk),
        .clr      (clr),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .ra       (ra),
        .rb       (rb),
        .rc       (rc),
        .imm      (imm),
        .done     (done),
        .err      (err),
        .result   (result),
        .bus_data (bus_data),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [3:0] c, input logic [DW-1:0] y,
                                            input logic [DW-1:0] b);
        logic signed [DW-1:0] sy;
        logic signed [63:0]   p;
        logic [4:0]           sh;
        sh = b[4:0];
        sy = y;
        case (c)
            4'd0:  return {32'h0, y + b};
            4'd1:  return {32'h0, y - b};
            4'd2:  return {32'h0, y & b};
            4'd3:  return {32'h0, y | b};
            4'd4:  return {32'h0, y << sh};
            4'd5:  return {32'h0, y >> sh};
            4'd6:  return {32'h0, DW'(sy >>> sh)};
            4'd7:  return {32'h0, ~y};
            4'd8:  return {32'h0, DW'(-sy)};
            4'd9: begin
                p = $signed(y) * $signed(b);
                return p;
            end
            4'd10, 4'd11: return {32'h0, y};
            default: return 64'h0;
        endcase
    endfunction

    // Monitor: retire first, then model any request the next edge will accept.
    always @(negedge clk) begin
        logic [63:0]   z;
        logic [DW-1:0] a, b, e;
        logic          ee;
        int            ac;
        cyc++;
        if (clr) begin
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 64'(done), 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ee = err_q.pop_front();
                    ac = acc_q.pop_front();
                    check("err", 64'(err), 64'(ee));
                    if (!ee) check("result", 64'(result), 64'(e));
                    check("latency", 64'(cyc - ac), 64'd4);
                end
            end
            if (op_valid && op_ready) begin
                a = (op_code == 4'd11) ? imm : m_regs[rb];
                b = m_regs[rc];
                z = ref_alu(op_code, a, b);
                if (op_code == 4'd9) begin
                    m_hi = z[63:32];
                    m_lo = z[31:0];
                end else if (op_code <= 4'd11) begin
                    m_regs[ra] = z[31:0];
                end
                exp_q.push_back(z[31:0]);
                err_q.push_back(op_code > 4'd11);
                acc_q.push_back(cyc);
                n_acc++;
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_hi = '0;
        m_lo = '0;
        exp_q.delete();
        err_q.delete();
        acc_q.delete();
    endtask

    task automatic send_op(input logic [3:0] c, input int d, input int s1, input int s2,
                           input logic [DW-1:0] v);
        logic got;
        got = 1'b0;
        @(posedge clk);
        #1;
        op_code  = c;
        ra       = AW'(d);
        rb       = AW'(s1);
        rc       = AW'(s2);
        imm      = v;
        op_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (op_ready) got = 1'b1;
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = 4'($urandom_range(0, 15));
        ra       = AW'($urandom_range(0, NR - 1));
        rb       = AW'($urandom_range(0, NR - 1));
        rc       = AW'($urandom_range(0, NR - 1));
        imm      = $urandom;
        if (!got) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) check("done_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_op(input logic [3:0] c, input int d, input int s1, input int s2,
                          input logic [DW-1:0] v);
        send_op(c, d, s1, s2, v);
        wait_idle();
    endtask

    task automatic check_reg(input int idx, input logic [DW-1:0] v);
        dbg_addr = AW'(idx);
        #1;
        check($sformatf("reg%0d", idx), 64'(dbg_data), 64'(v));
    endtask

    task automatic sweep_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            dbg_addr = AW'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), 64'(dbg_data), 64'(m_regs[i]));
        end
    endtask

    initial begin
        int base_done, base_acc;
        logic [3:0] mix_ops [7];
        mix_ops = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd10};

        clr = 1'b0; op_valid = 1'b0; op_code = '0;
        ra = '0; rb = '0; rc = '0; imm = '0; dbg_addr = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(op_ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bus", 64'(bus_data), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b1;

        // Reset mid-T1 of an ADD after R1 was loaded.
        run_op(4'd11, 1, 0, 0, 32'h0000_0005);
        check_reg(1, 32'h0000_0005);
        send_op(4'd0, 3, 1, 1, '0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
        @(negedge clk);
        sweep_regs("rst");
        check("rst_hi", 64'(hi_out), 64'd0);
        check("rst_lo", 64'(lo_out), 64'd0);
        check("rst_ready_mid", 64'(op_ready), 64'd1);
        @(posedge clk);
        #1;
        clr = 1'b1;
        base_done = n_done;
        repeat (8) @(negedge clk);
        check("rst_no_done", 64'(n_done - base_done), 64'd0);
        check_reg(3, 32'h0);

        // LDI and ADD with carry wrap.
        run_op(4'd11, 1, 0, 0, 32'h0000_0005);
        run_op(4'd11, 2, 0, 0, 32'hFFFF_FFFE);
        run_op(4'd0, 3, 1, 2, '0);
        check_reg(3, 32'h0000_0003);

        // SUB wrap and arithmetic shift right.
        run_op(4'd11, 1, 0, 0, 32'h0);
        run_op(4'd11, 2, 0, 0, 32'h1);
        run_op(4'd1, 4, 1, 2, '0);
        check_reg(4, 32'hFFFF_FFFF);
        run_op(4'd11, 7, 0, 0, 32'h8000_0000);
        run_op(4'd11, 8, 0, 0, 32'h0000_0004);
        run_op(4'd6, 9, 7, 8, '0);
        check_reg(9, 32'hF800_0000);

        // Signed multiply into HI/LO; ra untouched.
        run_op(4'd11, 5, 0, 0, 32'hFFFF_FFFD);
        run_op(4'd11, 6, 0, 0, 32'h0000_0007);
        run_op(4'd11, 10, 0, 0, 32'h1234_5678);
        run_op(4'd9, 10, 5, 6, '0);
        check("mul_hi", 64'(hi_out), 64'hFFFF_FFFF);
        check("mul_lo", 64'(lo_out), 64'hFFFF_FFEB);
        check_reg(10, 32'h1234_5678);

        // Remaining ALU ops; the shift source carries junk above the shift field.
        run_op(4'd11, 12, 0, 0, 32'hF0F0_1234);
        run_op(4'd11, 13, 0, 0, 32'h0F0F_00A5);
        foreach (mix_ops[k]) begin
            run_op(mix_ops[k], 14, 12, 13, '0);
            check_reg(14, m_regs[14]);
        end

        // Aliased operands, then op_valid held high for 12 cycles.
        run_op(4'd11, 1, 0, 0, 32'h0000_0006);
        run_op(4'd0, 1, 1, 1, '0);
        check_reg(1, 32'h0000_000C);
        @(posedge clk);
        #1;
        op_code = 4'd0; ra = 4'd1; rb = 4'd1; rc = 4'd1; op_valid = 1'b1;
        base_acc = n_acc;
        repeat (12) @(posedge clk);
        #1;
        op_valid = 1'b0;
        wait_idle();
        check("held_accepts", 64'(n_acc - base_acc), 64'd3);
        check_reg(1, 32'h0000_0060);

        // Illegal opcode: err with done, nothing written.
        run_op(4'd13, 2, 12, 13, 32'hDEAD_BEEF);
        sweep_regs("ill");
        check("ill_hi", 64'(hi_out), 64'(m_hi));
        check("ill_lo", 64'(lo_out), 64'(m_lo));

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
